clk_tick_monitor: RTL and testbench
===================================

Name: clk_tick_monitor

Overview:
- Board-domain consumer of the divided clock produced by the team's clock generator.
- Synchronizes the slow clock into the board clock domain and emits single-cycle rise/fall enable ticks, so downstream elevator logic runs on one clock with enables.
- Measures each half-period and runs a lock/loss watchdog, so the controller can refuse to move the car when the timing source is wrong or stalled.

Parameters:
- board_freq, 50000000, board clock frequency in Hz.
- module_freq, 1, nominal frequency of the monitored clock in Hz.
- TOL, 1024, allowed deviation of a half-period in board cycles.
- LOCK_COUNT, 2, number of consecutive in-tolerance half-periods required to assert locked.
- Derived: EXP_HALF = board_freq / (2*module_freq), in board cycles.

Ports:
- pulse  input  1  board clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- clk_in  input  1  divided clock, asynchronous to pulse.
- tick_rise  output  1  one-cycle pulse per synchronized rising edge of clk_in.
- tick_fall  output  1  one-cycle pulse per synchronized falling edge of clk_in.
- half_period  output  28  board cycles between the last two synchronized edges (saturating).
- locked  output  1  timing source within tolerance.
- lost  output  1  watchdog fired: no edge seen within EXP_HALF+TOL cycles, or out-of-tolerance period after lock.

Behaviour:
- Reset (rst_n=0 sampled on pulse rising edge):
  - Synchronizer flops and edge-history flop are set to 0.
  - cnt=0, good_cnt=0, state=IDLE.
  - All outputs are 0: tick_rise, tick_fall, half_period, locked, lost.
  - Reset applies mid-operation; no tick is emitted in the cycle after release.
- Synchronizer:
  - Two flops, s1<=clk_in and s2<=s1, plus a history flop s3<=s2.
  - Edge = s2^s3; rise = s2&~s3; fall = ~s2&s3.
  - Latency: a tick is asserted in the 3rd pulse cycle after clk_in changes, when the change meets setup at the first sample.
  - tick_rise and tick_fall are registered outputs, high for exactly one cycle.
  - Ticks are emitted in every state, including IDLE and LOST; consumers qualify them with locked.
- Counter:
  - 28-bit cnt increments every cycle and saturates at 2^28-1.
  - On an edge: half_period<=cnt+1 (saturating) and cnt<=0. Edge and increment in the same cycle gives edge priority.
  - A half-period is in-tolerance when EXP_HALF-TOL <= measured <= EXP_HALF+TOL. When TOL >= EXP_HALF, the lower bound is clamped to 1.
- State machine:
  - IDLE:
    - First edge -> MEASURE. This edge does not update half_period, because it is only a reference point.
    - cnt reaching EXP_HALF+TOL with no edge -> LOST.
  - MEASURE:
    - Each edge updates half_period.
    - In-tolerance edge: good_cnt++. When good_cnt reaches LOCK_COUNT -> LOCKED, and locked=1 in the cycle after that edge.
    - Out-of-tolerance edge: good_cnt<=0 and state stays MEASURE.
    - cnt reaching EXP_HALF+TOL -> LOST.
  - LOCKED:
    - locked=1.
    - Out-of-tolerance edge -> LOST.
    - cnt reaching EXP_HALF+TOL -> LOST.
  - LOST:
    - locked=0 and lost=1.
    - An edge resets good_cnt to 0 and goes to MEASURE; lost stays 1 while in MEASURE.
    - lost clears when LOCKED is re-entered.
    - lost is also cleared by reset.
  - Timeout and edge in the same cycle: the edge wins and no timeout fires.
  - LOCKED->LOST and the locked deassertion take effect in the same cycle in which lost rises.
- Width rules:
  - All comparisons are unsigned, 28 bits.
  - EXP_HALF+TOL must fit in 28 bits (elaboration-time check).

Test Plan:
- Params board_freq=20, module_freq=1 (EXP_HALF=10), TOL=2, LOCK_COUNT=2; clk_in toggles every 10 pulse cycles -> tick_rise/tick_fall one cycle wide, 3 cycles after each toggle; half_period=10; locked=1 after the 3rd edge; lost=0.
- Same params, locked, then clk_in held constant -> lost=1 and locked=0 when cnt reaches 12 after the last edge; ticks stop.
- Locked, then one half-period of 14 cycles -> lost=1 at the timeout (cnt=12). A half-period of 11 (within TOL) -> locked stays 1, half_period=11.
- From LOST, resume 10-cycle toggling -> state MEASURE with lost=1; after 2 good half-periods, locked=1 and lost=0.
- Alternate half-periods 10/5 -> locked never asserts, good_cnt keeps resetting, half_period shows 10 and 5 alternately.
- rst_n=0 for one cycle while locked with clk_in toggling -> next cycle all outputs are 0 and state is IDLE; relock requires 1 reference edge plus 2 good half-periods.

Source files
------------

// File: rtl/clk_tick_monitor.sv
// Synchronizes a slow divided clock into the board domain, emits rise/fall enable
// ticks, measures half-periods and runs a lock/loss watchdog on them.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | after reset, waiting for the first (reference) edge
// ST_MEASURE | counting consecutive in-tolerance half-periods toward lock
// ST_LOCKED  | timing source trusted, locked=1
// ST_LOST    | watchdog fired, waiting for an edge to start re-measuring
module clk_tick_monitor #(
    parameter int unsigned board_freq  = 50000000,
    parameter int unsigned module_freq = 1,
    parameter int unsigned TOL         = 1024,
    parameter int unsigned LOCK_COUNT  = 2
) (
    input  logic        pulse,
    input  logic        rst_n,
    input  logic        clk_in,
    output logic        tick_rise,
    output logic        tick_fall,
    output logic [27:0] half_period,
    output logic        locked,
    output logic        lost
);

    localparam longint unsigned EXP_HALF_L = 64'(board_freq) / (64'd2 * 64'(module_freq));
    localparam longint unsigned HI_L       = EXP_HALF_L + 64'(TOL);
    localparam longint unsigned LO_L       = (64'(TOL) >= EXP_HALF_L) ? 64'd1 : (EXP_HALF_L - 64'(TOL));
    localparam logic [27:0]     HI         = HI_L[27:0];
    localparam logic [27:0]     LO         = LO_L[27:0];
    localparam logic [15:0]     LOCK_N     = LOCK_COUNT[15:0];

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    if (HI_L > 64'h0FFF_FFFF) begin : g_hi_check
        $error("clk_tick_monitor: EXP_HALF+TOL does not fit in 28 bits");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 65535) begin : g_lock_check
        $error("clk_tick_monitor: LOCK_COUNT must be in 1..65535");
    end

    logic        s1_q, s2_q, s3_q;
    logic        tick_rise_q, tick_fall_q;
    logic [27:0] cnt_q, cnt_d;
    logic [27:0] half_period_q, half_period_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [1:0]  state_q, state_d;
    logic        locked_q, locked_d;
    logic        lost_q, lost_d;

    logic        edge_w, rise_w, fall_w;
    logic [27:0] meas_w;
    logic        in_tol_w, timeout_w;

    always_comb begin
        edge_w    = s2_q ^ s3_q;
        rise_w    = s2_q & ~s3_q;
        fall_w    = ~s2_q & s3_q;
        meas_w    = (cnt_q == 28'hFFF_FFFF) ? cnt_q : cnt_q + 28'd1;
        in_tol_w  = (meas_w >= LO) && (meas_w <= HI);
        // an edge in the same cycle as the limit suppresses the timeout
        timeout_w = (cnt_q >= HI) && !edge_w;

        cnt_d         = edge_w ? 28'd0 : meas_w;
        half_period_d = half_period_q;
        good_cnt_d    = good_cnt_q;
        state_d       = state_q;
        lost_d        = lost_q;

        case (state_q)
            ST_IDLE: begin
                if (edge_w) begin
                    state_d    = ST_MEASURE;
                    good_cnt_d = 16'd0;
                end else if (timeout_w) begin
                    state_d = ST_LOST;
                    lost_d  = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (edge_w) begin
                    half_period_d = meas_w;
                    if (in_tol_w) begin
                        good_cnt_d = good_cnt_q + 16'd1;
                        if (good_cnt_q + 16'd1 >= LOCK_N) begin
                            state_d = ST_LOCKED;
                            lost_d  = 1'b0;
                        end
                    end else begin
                        good_cnt_d = 16'd0;
                    end
                end else if (timeout_w) begin
                    state_d = ST_LOST;
                    lost_d  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (edge_w) begin
                    half_period_d = meas_w;
                    if (!in_tol_w) begin
                        state_d = ST_LOST;
                        lost_d  = 1'b1;
                    end
                end else if (timeout_w) begin
                    state_d = ST_LOST;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                if (edge_w) begin
                    half_period_d = meas_w;
                    good_cnt_d    = 16'd0;
                    state_d       = ST_MEASURE;
                end
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge pulse) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            tick_rise_q   <= 1'b0;
            tick_fall_q   <= 1'b0;
            cnt_q         <= 28'd0;
            half_period_q <= 28'd0;
            good_cnt_q    <= 16'd0;
            state_q       <= ST_IDLE;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            s1_q          <= clk_in;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            tick_rise_q   <= rise_w;
            tick_fall_q   <= fall_w;
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            good_cnt_q    <= good_cnt_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
        end
    end

    assign tick_rise   = tick_rise_q;
    assign tick_fall   = tick_fall_q;
    assign half_period = half_period_q;
    assign locked      = locked_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Directed bench for clk_tick_monitor with EXP_HALF=10, TOL=2 (window 8..12), LOCK_COUNT=2.
module tb_clk_tick_monitor;

    logic        pulse = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_in = 1'b0;
    logic        tick_rise, tick_fall, locked, lost;
    logic [27:0] half_period;

    int errors = 0;
    int checks = 0;

    // per-call samples, index = cycles since the call started (1..n)
    logic        tr [0:31];
    logic        tf [0:31];
    logic        lk [0:31];
    logic        ls [0:31];
    logic [27:0] hpv [0:31];
    int          nr, nf, nlk;

    clk_tick_monitor #(
        .board_freq (20),
        .module_freq(1),
        .TOL        (2),
        .LOCK_COUNT (2)
    ) dut (
        .pulse      (pulse),
        .rst_n      (rst_n),
        .clk_in     (clk_in),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .half_period(half_period),
        .locked     (locked),
        .lost       (lost)
    );

    always #5 pulse = ~pulse;

    // optionally toggle clk_in, then run n board cycles sampling #1 after each edge
    task automatic advance(input int n, input bit tog);
        if (tog) clk_in = ~clk_in;
        nr = 0; nf = 0; nlk = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge pulse); #1;
            tr[j] = tick_rise; tf[j] = tick_fall; lk[j] = locked; ls[j] = lost; hpv[j] = half_period;
            if (tick_rise) nr++;
            if (tick_fall) nf++;
            if (locked) nlk++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_in = 1'b0;
        repeat (3) begin @(posedge pulse); #1; end
        checks++; if (tick_rise !== 1'b0) begin errors++; $display("FAIL reset_tick_rise: got %b expected 0", tick_rise); end
        checks++; if (tick_fall !== 1'b0) begin errors++; $display("FAIL reset_tick_fall: got %b expected 0", tick_fall); end
        checks++; if (half_period !== 28'd0) begin errors++; $display("FAIL reset_half_period: got %0d expected 0", half_period); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b expected 0", lost); end
        rst_n = 1'b1;
        @(posedge pulse); #1;
        checks++; if ({tick_rise, tick_fall} !== 2'b00) begin errors++; $display("FAIL release_no_tick: got %b expected 00", {tick_rise, tick_fall}); end
    endtask

    task automatic test_lock();
        advance(10, 1'b1);
        checks++; if (nr !== 1 || tr[3] !== 1'b1) begin errors++; $display("FAIL lock_rise_tick: count %0d at3 %b expected 1 and 1", nr, tr[3]); end
        checks++; if (nf !== 0) begin errors++; $display("FAIL lock_no_fall: got %0d expected 0", nf); end
        checks++; if (hpv[10] !== 28'd0) begin errors++; $display("FAIL lock_ref_edge_hp: got %0d expected 0", hpv[10]); end
        advance(10, 1'b1);
        checks++; if (nf !== 1 || tf[3] !== 1'b1) begin errors++; $display("FAIL lock_fall_tick: count %0d at3 %b expected 1 and 1", nf, tf[3]); end
        checks++; if (hpv[10] !== 28'd10 || lk[10] !== 1'b0) begin errors++; $display("FAIL lock_edge2: hp %0d locked %b expected 10 0", hpv[10], lk[10]); end
        advance(10, 1'b1);
        checks++; if (lk[2] !== 1'b0 || lk[3] !== 1'b1) begin errors++; $display("FAIL lock_assert: at2 %b at3 %b expected 0 1", lk[2], lk[3]); end
        checks++; if (ls[10] !== 1'b0 || hpv[10] !== 28'd10) begin errors++; $display("FAIL lock_state: lost %b hp %0d expected 0 10", ls[10], hpv[10]); end
    endtask

    task automatic test_hold_loss();
        advance(10, 1'b0);
        checks++; if (ls[5] !== 1'b0 || lk[5] !== 1'b1) begin errors++; $display("FAIL hold_before_timeout: lost %b locked %b expected 0 1", ls[5], lk[5]); end
        checks++; if (ls[6] !== 1'b1 || lk[6] !== 1'b0) begin errors++; $display("FAIL hold_timeout: lost %b locked %b expected 1 0", ls[6], lk[6]); end
        checks++; if (nr + nf !== 0) begin errors++; $display("FAIL hold_no_ticks: got %0d expected 0", nr + nf); end
    endtask

    task automatic test_recover();
        advance(10, 1'b1);
        checks++; if (ls[10] !== 1'b1 || lk[10] !== 1'b0 || nf !== 1) begin errors++; $display("FAIL recover_first: lost %b locked %b falls %0d expected 1 0 1", ls[10], lk[10], nf); end
        advance(10, 1'b1);
        checks++; if (ls[10] !== 1'b1 || lk[10] !== 1'b0 || hpv[10] !== 28'd10) begin errors++; $display("FAIL recover_good1: lost %b locked %b hp %0d expected 1 0 10", ls[10], lk[10], hpv[10]); end
        advance(10, 1'b1);
        checks++; if (lk[2] !== 1'b0 || lk[3] !== 1'b1 || ls[2] !== 1'b1 || ls[3] !== 1'b0) begin errors++; $display("FAIL recover_relock: locked %b%b lost %b%b expected 01 10", lk[2], lk[3], ls[2], ls[3]); end
    endtask

    task automatic test_tolerance();
        advance(11, 1'b1);
        checks++; if (lk[11] !== 1'b1 || hpv[11] !== 28'd10) begin errors++; $display("FAIL tol_pre: locked %b hp %0d expected 1 10", lk[11], hpv[11]); end
        advance(14, 1'b1);
        checks++; if (lk[14] !== 1'b1 || ls[14] !== 1'b0 || hpv[14] !== 28'd11) begin errors++; $display("FAIL tol_11: locked %b lost %b hp %0d expected 1 0 11", lk[14], ls[14], hpv[14]); end
        advance(10, 1'b1);
        checks++; if (ls[1] !== 1'b0 || lk[1] !== 1'b1) begin errors++; $display("FAIL tol_14_before: lost %b locked %b expected 0 1", ls[1], lk[1]); end
        checks++; if (ls[2] !== 1'b1 || lk[2] !== 1'b0) begin errors++; $display("FAIL tol_14_timeout: lost %b locked %b expected 1 0", ls[2], lk[2]); end
        checks++; if (ls[10] !== 1'b1 || lk[10] !== 1'b0) begin errors++; $display("FAIL tol_14_after: lost %b locked %b expected 1 0", ls[10], lk[10]); end
    endtask

    task automatic test_alternate();
        int gaps [6] = '{5, 10, 5, 10, 10, 10};
        logic [27:0] exp_hp [6] = '{28'd10, 28'd5, 28'd10, 28'd5, 28'd10, 28'd10};
        int lk_total = 0;
        for (int i = 0; i < 5; i++) begin
            advance(gaps[i], 1'b1);
            lk_total += nlk;
            checks++; if (hpv[gaps[i]] !== exp_hp[i]) begin errors++; $display("FAIL alt_hp_%0d: got %0d expected %0d", i, hpv[gaps[i]], exp_hp[i]); end
        end
        checks++; if (lk_total !== 0) begin errors++; $display("FAIL alt_never_locked: got %0d locked cycles expected 0", lk_total); end
        checks++; if (ls[10] !== 1'b1) begin errors++; $display("FAIL alt_lost_held: got %b expected 1", ls[10]); end
        advance(gaps[5], 1'b1);
        checks++; if (lk[3] !== 1'b1 || ls[3] !== 1'b0 || hpv[10] !== exp_hp[5]) begin errors++; $display("FAIL alt_relock: locked %b lost %b hp %0d expected 1 0 10", lk[3], ls[3], hpv[10]); end
    endtask

    task automatic test_reset_midop();
        advance(5, 1'b1);
        checks++; if (lk[5] !== 1'b1) begin errors++; $display("FAIL midrst_pre_locked: got %b expected 1", lk[5]); end
        rst_n = 1'b0;
        @(posedge pulse); #1;
        rst_n = 1'b1;
        checks++; if ({tick_rise, tick_fall, locked, lost} !== 4'b0000 || half_period !== 28'd0) begin errors++; $display("FAIL midrst_outputs: flags %b hp %0d expected 0000 0", {tick_rise, tick_fall, locked, lost}, half_period); end
        advance(10, 1'b1);
        checks++; if (tr[3] !== 1'b1 || hpv[10] !== 28'd0 || lk[10] !== 1'b0 || ls[10] !== 1'b0) begin errors++; $display("FAIL midrst_ref: rise %b hp %0d locked %b lost %b expected 1 0 0 0", tr[3], hpv[10], lk[10], ls[10]); end
        advance(10, 1'b1);
        checks++; if (hpv[10] !== 28'd10 || lk[10] !== 1'b0) begin errors++; $display("FAIL midrst_good1: hp %0d locked %b expected 10 0", hpv[10], lk[10]); end
        advance(10, 1'b1);
        checks++; if (lk[2] !== 1'b0 || lk[3] !== 1'b1 || ls[10] !== 1'b0) begin errors++; $display("FAIL midrst_relock: locked %b%b lost %b expected 01 0", lk[2], lk[3], ls[10]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_lock();
        test_hold_loss();
        test_recover();
        test_tolerance();
        test_alternate();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
